xctcmsg_bus_arbiter: RTL

Shares one network-side message bus between N_PORTS functional-unit requesters. Each requester connects with the FU-role signal set: send val/ack and receive rdy/val. The single downstream port drives the network with the same signal set. Sends are arbitrated round-robin and latched into an output register held until the network acks. Receives are captured in a one-entry buffer and routed to a requester selected by the low bits of the message tag.

---
 rtl/xctcmsg_pkg.sv | 24 ++
 rtl/xctcmsg_rr_arbiter.sv | 35 +++
 rtl/xctcmsg_bus_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/xctcmsg_pkg.sv
// Shared message types for the xctcmsg bus arbiter.
// Field widths plus the latched send bundle and send FSM states.
package xctcmsg_pkg;

  localparam int ADDR_W = 8;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] message_addr_t;
  typedef logic [TAG_W-1:0]  message_tag_t;
  typedef logic [DATA_W-1:0] message_data_t;

  typedef struct packed {
    message_addr_t dst;
    message_tag_t  tag;
    message_data_t msg;
  } bus_send_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } send_state_e;

endpackage

// File: rtl/xctcmsg_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr_i,
// wrapping. Ports: req_i, ptr_i in; gnt_o (one-hot), idx_o, any_o out.
module xctcmsg_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // N is a power of two, so the IDX_W-bit add wraps naturally.
  always_comb begin
    cand  = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_i + IDX_W'(i);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/xctcmsg_bus_arbiter.sv
// Shares one network message bus among N_PORTS FU requesters.
// Ports: req_* (FU side: send val/ack + fields, receive rdy/val + fields),
// bus_* (network side: send val/ack + fields, receive rdy/val + fields).
module xctcmsg_bus_arbiter
  import xctcmsg_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_PORTS-1:0]           req_val_i,
  output logic [N_PORTS-1:0]           req_ack_o,
  input  message_addr_t [N_PORTS-1:0]  req_dst_i,
  input  message_tag_t  [N_PORTS-1:0]  req_tag_i,
  input  message_data_t [N_PORTS-1:0]  req_msg_i,
  input  logic [N_PORTS-1:0]           req_rdy_i,
  output logic [N_PORTS-1:0]           req_val_o,
  output message_addr_t                req_src_o,
  output message_tag_t                 req_tag_o,
  output message_data_t                req_msg_o,
  output logic                         bus_val_o,
  input  logic                         bus_ack_i,
  output message_addr_t                bus_dst_o,
  output message_tag_t                 bus_tag_o,
  output message_data_t                bus_msg_o,
  output logic                         bus_rdy_o,
  input  logic                         bus_val_i,
  input  message_addr_t                bus_src_i,
  input  message_tag_t                 bus_tag_i,
  input  message_data_t                bus_msg_i
);

  // ---------------- send path ----------------
  send_state_e      state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  bus_send_t        send_q, send_d;

  logic [N_PORTS-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  xctcmsg_rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req_val_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      send_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      send_q   <= send_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    send_d   = send_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          state_d    = S_BUSY;
          gnt_d      = arb_idx;
          send_d.dst = req_dst_i[arb_idx];
          send_d.tag = req_tag_i[arb_idx];
          send_d.msg = req_msg_i[arb_idx];
        end
      end
      S_BUSY: begin
        if (bus_ack_i) begin
          state_d  = S_IDLE;
          rr_ptr_d = gnt_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_val_o = (state_q == S_BUSY);
    req_ack_o = '0;
    if (bus_val_o && bus_ack_i) begin
      req_ack_o[gnt_q] = 1'b1;
    end
  end

  assign bus_dst_o = send_q.dst;
  assign bus_tag_o = send_q.tag;
  assign bus_msg_o = send_q.msg;

  // ---------------- receive path ----------------
  logic             full_q, full_d;
  logic             rdy_en_q;
  logic [IDX_W-1:0] rdst_q, rdst_d;
  message_addr_t    rsrc_q, rsrc_d;
  message_tag_t     rtag_q, rtag_d;
  message_data_t    rmsg_q, rmsg_d;
  logic             cap, cons;

  // Keeps bus_rdy_o low while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_en_q <= 1'b0;
    else         rdy_en_q <= 1'b1;
  end

  assign bus_rdy_o = rdy_en_q & ~full_q;
  assign cap       = bus_val_i & bus_rdy_o;
  assign cons      = full_q & req_rdy_i[rdst_q];

  always_comb begin
    full_d = full_q;
    rdst_d = rdst_q;
    rsrc_d = rsrc_q;
    rtag_d = rtag_q;
    rmsg_d = rmsg_q;
    if (cons) full_d = 1'b0;
    if (cap) begin
      full_d = 1'b1;
      rdst_d = bus_tag_i[IDX_W-1:0];
      rsrc_d = bus_src_i;
      rtag_d = bus_tag_i;
      rmsg_d = bus_msg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      rdst_q <= '0;
      rsrc_q <= '0;
      rtag_q <= '0;
      rmsg_q <= '0;
    end else begin
      full_q <= full_d;
      rdst_q <= rdst_d;
      rsrc_q <= rsrc_d;
      rtag_q <= rtag_d;
      rmsg_q <= rmsg_d;
    end
  end

  always_comb begin
    req_val_o = '0;
    if (full_q) req_val_o[rdst_q] = 1'b1;
  end

  assign req_src_o = rsrc_q;
  assign req_tag_o = rtag_q;
  assign req_msg_o = rmsg_q;

endmodule
